// File: rtl/spi_mem_slave.sv
// SPI mode-0 slave fronting a register-file memory: command word (R/W + address) followed by
// burst data words with address auto-increment, abort detection and address fault injection.
module spi_mem_slave #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned FAULT_BIT  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    input  logic       fault_inject,
    output logic       miso_pin,
    output logic       miso_oe,
    output logic       busy,
    output logic       frame_err,
    output logic [2:0] state
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned CMD_WIDTH = ADDR_WIDTH + 1;
    localparam int unsigned SW        = (CMD_WIDTH > DATA_WIDTH) ? CMD_WIDTH : DATA_WIDTH;
    localparam int unsigned CW        = $clog2(SW + 1);

    localparam logic [CW-1:0]         CMD_LAST   = CW'(CMD_WIDTH - 1);
    localparam logic [CW-1:0]         DATA_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] FAULT_MASK = ADDR_WIDTH'(1) << FAULT_BIT;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CMD       = 3'd1;
    localparam logic [2:0] S_RD_FETCH  = 3'd2;
    localparam logic [2:0] S_RD_SHIFT  = 3'd3;
    localparam logic [2:0] S_WR_SHIFT  = 3'd4;
    localparam logic [2:0] S_WR_COMMIT = 3'd5;
    localparam logic [2:0] S_WAIT_CS   = 3'd6;

    logic [1:0] sclk_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sclk_prev_q;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]         shreg_q, shreg_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  miso_oe_q, miso_oe_d;
    logic                  frame_err_q, frame_err_d;
    logic                  mem_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic          sclk_rise;
    logic          sclk_fall;
    logic          cs_high;
    logic          mosi_s;
    logic [SW-1:0] shift_in;
    logic          abort;
    logic          mid_word_state;

    // Chip select idles high, so its synchroniser resets to 1 to avoid a spurious frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk_pin};
            cs_sync_q   <= {cs_sync_q[0], cs_pin};
            mosi_sync_q <= {mosi_sync_q[0], mosi_pin};
            sclk_prev_q <= sclk_sync_q[1];
        end
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
    assign cs_high   = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign shift_in  = {shreg_q[SW-2:0], mosi_s};

    assign mid_word_state = (state_q == S_CMD) || (state_q == S_RD_SHIFT) ||
                            (state_q == S_WR_SHIFT);
    // A pending commit must land before the frame closes, so WR_COMMIT is not abortable.
    assign abort = cs_high && (state_q != S_IDLE) && (state_q != S_WR_COMMIT);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        addr_d      = addr_q;
        miso_oe_d   = miso_oe_q;
        frame_err_d = 1'b0;
        mem_we      = 1'b0;

        if (abort) begin
            state_d     = S_IDLE;
            bit_cnt_d   = '0;
            miso_oe_d   = 1'b0;
            frame_err_d = mid_word_state && (bit_cnt_q != '0);
        end else begin
            case (state_q)
                S_IDLE: begin
                    miso_oe_d = 1'b0;
                    bit_cnt_d = '0;
                    if (!cs_high) begin
                        state_d = S_CMD;
                        shreg_d = '0;
                    end
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        shreg_d = shift_in;
                        if (bit_cnt_q == CMD_LAST) begin
                            bit_cnt_d = '0;
                            addr_d    = shift_in[ADDR_WIDTH-1:0] |
                                        (fault_inject ? FAULT_MASK : '0);
                            state_d   = shift_in[ADDR_WIDTH] ? S_RD_FETCH : S_WR_SHIFT;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_RD_FETCH: begin
                    shreg_d   = SW'(mem[addr_q]);
                    miso_oe_d = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = S_RD_SHIFT;
                end
                S_RD_SHIFT: begin
                    if (sclk_rise) begin
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
                            addr_d    = addr_q + 1'b1;
                            state_d   = S_RD_FETCH;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else if (sclk_fall && (bit_cnt_q != '0)) begin
                        // The fall before the first rise of a word must keep the MSB in place.
                        shreg_d = shreg_q << 1;
                    end
                end
                S_WR_SHIFT: begin
                    if (sclk_rise) begin
                        shreg_d = shift_in;
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = S_WR_COMMIT;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_WR_COMMIT: begin
                    mem_we  = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    state_d = cs_high ? S_IDLE : S_WR_SHIFT;
                end
                S_WAIT_CS: begin
                    miso_oe_d = 1'b0;
                end
                default: begin
                    state_d   = S_IDLE;
                    miso_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            addr_q      <= '0;
            miso_oe_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            addr_q      <= addr_d;
            miso_oe_q   <= miso_oe_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= shreg_q[DATA_WIDTH-1:0];
        end
    end

    assign miso_pin  = miso_oe_q & shreg_q[DATA_WIDTH-1];
    assign miso_oe   = miso_oe_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_err = frame_err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_spi_mem_slave.sv
// Bench for spi_mem_slave: directed frames plus random bursts checked against a byte-array model.
module tb_spi_mem_slave;

    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk_pin, cs_pin, mosi_pin, fault_inject;
    logic       miso_pin, miso_oe, busy, frame_err;
    logic [2:0] state;

    logic [7:0] ref_mem [128];

    int n_checks = 0;
    int n_errors = 0;
    int fe_cnt = 0;
    int fe_run = 0;
    int fe_maxrun = 0;

    spi_mem_slave dut (
        .clk          (clk),
        .reset        (reset),
        .sclk_pin     (sclk_pin),
        .cs_pin       (cs_pin),
        .mosi_pin     (mosi_pin),
        .fault_inject (fault_inject),
        .miso_pin     (miso_pin),
        .miso_oe      (miso_oe),
        .busy         (busy),
        .frame_err    (frame_err),
        .state        (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) begin
            fe_cnt++;
            fe_run++;
            if (fe_run > fe_maxrun) fe_maxrun = fe_run;
        end else begin
            fe_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m, output logic o);
        mosi_pin = b;
        repeat (HALF) @(negedge clk);
        m = miso_pin;
        o = miso_oe;
        sclk_pin = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk_pin = 1'b0;
    endtask

    // Command byte, then nbits of wbits MSB first; MISO is captured before every data rise.
    task automatic frame(input logic rw, input logic [6:0] addr, input int nbits,
                         input logic [31:0] wbits, output logic [31:0] rbits, output int oe_bad);
        logic [7:0] cmd;
        logic m, o;
        cmd = {rw, addr};
        rbits = '0;
        oe_bad = 0;
        cs_pin = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], m, o);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bit(wbits[i], m, o);
            rbits = {rbits[30:0], m};
            if (rw && (o !== 1'b1)) oe_bad++;
        end
        repeat (4) @(negedge clk);
        cs_pin = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    function automatic logic [7:0] word_of(input logic [31:0] bits, input int nb, input int k);
        return 8'((bits >> (nb - 8 * (k + 1))) & 32'hFF);
    endfunction

    logic [31:0] rd, expv;
    int ob, fe0;
    logic m, o;

    initial begin
        reset = 1'b1;
        sclk_pin = 1'b0;
        cs_pin = 1'b1;
        mosi_pin = 1'b0;
        fault_inject = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_miso", 32'(miso_pin), 32'd0);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single write, then read back
        frame(1'b0, 7'h00, 8, 32'hCC, rd, ob);
        ref_mem[0] = 8'hCC;
        check("wr_state", 32'(state), 32'd0);
        check("wr_busy", 32'(busy), 32'd0);
        check("wr_ferr", 32'(fe_cnt), 32'd0);
        frame(1'b1, 7'h00, 8, 32'h0, rd, ob);
        check("rd_00", rd, 32'(ref_mem[0]));
        check("rd_00_oe", 32'(ob), 32'd0);

        // Burst write and read across the top of memory
        frame(1'b0, 7'h7F, 16, 32'hA55A, rd, ob);
        ref_mem[127] = 8'hA5;
        ref_mem[0] = 8'h5A;
        frame(1'b1, 7'h7F, 16, 32'h0, rd, ob);
        check("burst_wrap", rd, {16'h0, ref_mem[127], ref_mem[0]});
        check("burst_oe", 32'(ob), 32'd0);
        check("burst_ferr", 32'(fe_cnt), 32'd0);

        // Abort after 5 data bits
        frame(1'b0, 7'h10, 8, 32'h3C, rd, ob);
        ref_mem[16] = 8'h3C;
        fe0 = fe_cnt;
        frame(1'b0, 7'h10, 5, 32'h1F, rd, ob);
        check("abort_ferr", 32'(fe_cnt - fe0), 32'd1);
        check("abort_state", 32'(state), 32'd0);
        frame(1'b1, 7'h10, 8, 32'h0, rd, ob);
        check("abort_nowrite", rd, 32'(ref_mem[16]));

        // Fault injection redirects 0x01 to 0x05
        frame(1'b0, 7'h01, 8, 32'h77, rd, ob);
        ref_mem[1] = 8'h77;
        fault_inject = 1'b1;
        frame(1'b0, 7'h01, 8, 32'h11, rd, ob);
        fault_inject = 1'b0;
        ref_mem[5] = 8'h11;
        frame(1'b1, 7'h05, 8, 32'h0, rd, ob);
        check("fault_05", rd, 32'(ref_mem[5]));
        frame(1'b1, 7'h01, 8, 32'h0, rd, ob);
        check("fault_01", rd, 32'(ref_mem[1]));

        // Reset in the middle of a read
        frame(1'b0, 7'h00, 8, 32'hCC, rd, ob);
        ref_mem[0] = 8'hCC;
        cs_pin = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 0; i--) spi_bit((i == 7) ? 1'b1 : 1'b0, m, o);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, m, o);
        check("pre_rst_oe", 32'(miso_oe), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_miso", 32'(miso_pin), 32'd0);
        check("mid_rst_oe", 32'(miso_oe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        cs_pin = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        frame(1'b1, 7'h00, 8, 32'h0, rd, ob);
        check("post_rst_rd", rd, 32'(ref_mem[0]));

        // Random bursts with optional fault redirect and optional mid-word abort
        for (int it = 0; it < 12; it++) begin
            int a, n, ab, nb, ea;
            logic fi;
            logic [31:0] wd;
            a  = int'($urandom_range(0, 127));
            n  = int'($urandom_range(1, 3));
            fi = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
            nb = n * 8 + ab;
            wd = $urandom;
            ea = fi ? (a | 4) : a;
            for (int k = 0; k < n; k++) ref_mem[(ea + k) % 128] = word_of(wd, nb, k);
            fault_inject = fi;
            fe0 = fe_cnt;
            frame(1'b0, 7'(a), nb, wd, rd, ob);
            fault_inject = 1'b0;
            check("rnd_ferr", 32'(fe_cnt - fe0), (ab != 0) ? 32'd1 : 32'd0);
            check("rnd_state", 32'(state), 32'd0);
            expv = '0;
            for (int k = 0; k < n; k++) expv = {expv[23:0], ref_mem[(ea + k) % 128]};
            frame(1'b1, 7'(ea), n * 8, 32'h0, rd, ob);
            check("rnd_rd", rd, expv);
            check("rnd_oe", 32'(ob), 32'd0);
        end

        check("ferr_width", 32'(fe_maxrun), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_mem_slave.md
Name: spi_mem_slave

Overview:
- Parametrised SPI (mode 0) slave that fronts an internal register-file memory.
- Successor to the fixed 8-bit, single-byte-per-frame SPI memory.
- Generalised data and address width; burst read/write with address auto-increment and wrap-around.
- Adds async reset, frame-abort detection and a configurable fault-injection bit.
- Sits between the board SPI pins and debug LEDs/state display, on the system clock.

Parameters:
DATA_WIDTH, 8, bits per data word and memory word
ADDR_WIDTH, 7, address bits; memory depth = 2**ADDR_WIDTH
FAULT_BIT, 2, address bit forced to 1 while fault_inject is high (0..ADDR_WIDTH-1)

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
sclk_pin  in  1  raw SPI clock, asynchronous
cs_pin  in  1  raw chip select, active-low, asynchronous
mosi_pin  in  1  raw serial data in, asynchronous
fault_inject  in  1  when high, latched address has bit FAULT_BIT forced to 1
miso_pin  out  1  serial data out
miso_oe  out  1  high while MISO carries valid read data
busy  out  1  high whenever state is not IDLE
frame_err  out  1  one-clk pulse on a word-aborting CS rise
state  out  3  current FSM state encoding (debug/LEDs)

Behaviour:
- Reset (async assert, sync release) sets:
  - miso_pin=0, miso_oe=0, busy=0, frame_err=0, state=IDLE(0).
  - Address register, bit counter and shift register cleared.
  - Memory contents are not reset.
- Input conditioning:
  - Each raw pin passes through a 2-flop synchroniser.
  - sclk rise/fall pulses are derived from the synchronised value: 1 clk wide, 3 clk after the pin edge.
  - The host guarantees sclk half-period >= 8 clk.
- Frame format, MSB first, sampled on sclk rise:
  - Command: ADDR_WIDTH+1 bits. First bit is R/W (1=read); the remaining bits are the address.
  - Then any number of DATA_WIDTH-bit words while CS is low.
- State encoding: IDLE=0, CMD=1, RD_FETCH=2, RD_SHIFT=3, WR_SHIFT=4, WR_COMMIT=5, WAIT_CS=6.
- IDLE -> CMD on synchronised CS low; bit counter cleared.
- CMD:
  - Shift MOSI on each sclk rise.
  - After bit ADDR_WIDTH+1, latch the address, with bit FAULT_BIT ORed with fault_inject.
  - Go to RD_FETCH if R/W=1, else WR_SHIFT.
- RD_FETCH:
  - Synchronous memory read, 1 clk latency; load the word into the shift register.
  - Drive its MSB on miso_pin and set miso_oe=1 in the load cycle; go to RD_SHIFT.
  - Total delay from the last command rise is <= 4 clk, so data is ready before the next falling edge.
- RD_SHIFT:
  - miso_pin advances one bit on each sclk fall.
  - After the DATA_WIDTH-th rise: address <= address+1 mod 2**ADDR_WIDTH, then RD_FETCH.
  - The MSB of the next word must be on MISO before the following sclk rise.
- WR_SHIFT: shift MOSI on each sclk rise; after DATA_WIDTH bits go to WR_COMMIT.
- WR_COMMIT:
  - Write mem[address] in 1 clk.
  - address <= address+1 mod 2**ADDR_WIDTH; back to WR_SHIFT.
- CS high:
  - From any non-IDLE state, return to IDLE on the next clk; miso_oe=0 and miso_pin=0.
  - If the CS rise arrives with the bit counter mid-command or mid-data-word (nonzero, < width):
    - frame_err pulses for exactly 1 clk.
    - The partial word is discarded; no memory write occurs.
  - A CS rise exactly on a word boundary is clean: no error.
  - A pending WR_COMMIT always completes before IDLE.
- WAIT_CS:
  - Entered if sclk toggles while the address overflow path is inhibited (reserved).
  - Implementations may treat it as IDLE-equivalent; it must exit on CS high.
- Simultaneous events:
  - CS rise in the same clk as an sclk rise: CS wins, and that sclk edge is ignored.
  - reset overrides everything, mid-transfer included.
- miso_pin is 0 whenever miso_oe=0.

Test Plan:
- Write 0xCC to address 0x00: CS low, bits 0_0000000 then 11001100, CS high -> mem[0x00]=0xCC, frame_err never high, state returns to 0, busy falls.
- Read address 0x00: command 1_0000000 -> miso_oe=1 and MISO sampled on 8 rises = 1,1,0,0,1,1,0,0.
- Burst write at 0x7F of words 0xA5, 0x5A -> mem[0x7F]=0xA5, mem[0x00]=0x5A (wrap). Burst read from 0x7F returns 0xA5 then 0x5A.
- Write to 0x10 with CS raised after 5 data bits -> frame_err high for exactly 1 clk, mem[0x10] unchanged, state=0.
- fault_inject=1, write 0x11 to address 0x01 -> data lands at 0x05. Read 0x05 with fault_inject=0 -> 0x11; mem[0x01] unchanged.
- Assert reset for 2 clk mid-read at bit 3 -> immediately miso_pin=0, miso_oe=0, busy=0, state=0. A subsequent read of 0x00 returns 0xCC.
